// File: rtl/fml_mem_responder_pkg.sv
// Shared types and constants for the COP memory responder.
// State encodings, LFSR tap mask and stall-draw helper.
package fml_mem_responder_pkg;

    typedef enum logic [1:0] {
        FML_MR_IDLE  = 2'd0,
        FML_MR_STALL = 2'd1,
        FML_MR_DONE  = 2'd2
    } fml_mr_state_e;

    // Right-shifting Fibonacci form of taps 16,14,13,11:
    // feedback is bits 0,2,3,5, inserted at bit 15.
    localparam logic [15:0] FML_LFSR_TAPS = 16'h002D;

    function automatic logic [3:0] fml_stall_draw(
        input logic [15:0] r,
        input logic [3:0]  smax
    );
        return (r[3:0] > smax) ? smax : r[3:0];
    endfunction

endpackage

// File: rtl/fml_lfsr16.sv
// 16-bit Fibonacci LFSR, advances only when en is high.
// Seed must be non-zero or the sequence locks up.
module fml_lfsr16
    import fml_mem_responder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        en,
    output logic [15:0] q
);

    // Shift right, feedback enters at the top bit.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            q <= SEED;
        end else if (en) begin
            q <= {^(q & FML_LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/fml_mem_responder.sv
// Responder end of the COP memory interface: word RAM with
// bounded pseudo-random stalls and an address-window bus error.
module fml_mem_responder
    import fml_mem_responder_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter int          STALL_MAX = 3,
    parameter logic [31:0] ERR_BASE  = 32'hF000_0000,
    parameter logic [31:0] ERR_LIMIT = 32'hF000_1000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    input  logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_rdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,
    input  logic        cfg_stall_en,
    input  logic        cfg_err_en,
    output logic [15:0] txn_count,
    output logic        proto_err
);

    localparam logic [3:0] SMAX = 4'(STALL_MAX);

    fml_mr_state_e      state;
    fml_mr_state_e      state_n;
    logic [3:0]         cnt;
    logic [3:0]         k;
    logic               accept;
    logic               err;
    logic               err_hold;
    logic [15:0]        lfsr_q;
    logic [MEM_AW-1:0]  idx;
    logic [31:0]        mem [2**MEM_AW];

    assign accept = cop_mem_cen && (state != FML_MR_STALL);
    assign idx    = cop_mem_addr[MEM_AW+1:2];
    assign err    = cfg_err_en
                 && (cop_mem_addr >= ERR_BASE)
                 && (cop_mem_addr <  ERR_LIMIT);
    assign k      = cfg_stall_en ? fml_stall_draw(lfsr_q, SMAX) : 4'd0;

    fml_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .en       (accept),
        .q        (lfsr_q)
    );

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= FML_MR_IDLE;
        else           state <= state_n;
    end

    // Next state: accept from IDLE or DONE, count down in STALL.
    always_comb begin
        state_n = state;
        unique case (state)
            FML_MR_IDLE, FML_MR_DONE: begin
                if (!accept)      state_n = FML_MR_IDLE;
                else if (k != 0)  state_n = FML_MR_STALL;
                else              state_n = FML_MR_DONE;
            end
            FML_MR_STALL: begin
                if (cnt == 4'd1) state_n = FML_MR_DONE;
            end
            default: state_n = FML_MR_IDLE;
        endcase
    end

    // Response registers, driven from next state so outputs stay registered.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt           <= 4'd0;
            err_hold      <= 1'b0;
            cop_mem_rdata <= 32'd0;
            cop_mem_stall <= 1'b0;
            cop_mem_error <= 1'b0;
            txn_count     <= 16'd0;
            proto_err     <= 1'b0;
        end else begin
            cop_mem_stall <= (state_n == FML_MR_STALL);
            cop_mem_error <= (state_n == FML_MR_DONE)
                          && (accept ? err : err_hold);
            if (accept) begin
                cnt       <= k;
                err_hold  <= err;
                txn_count <= txn_count + 16'd1;
                cop_mem_rdata <= (cop_mem_wen || err) ? 32'd0 : mem[idx];
            end else if (state == FML_MR_STALL) begin
                cnt <= cnt - 4'd1;
                if (!cop_mem_cen) proto_err <= 1'b1;
            end
        end
    end

    // Byte-masked RAM write at the accept edge; RAM is never reset.
    always_ff @(posedge g_clk) begin
        if (accept && cop_mem_wen && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (cop_mem_ben[i])
                    mem[idx][8*i +: 8] <= cop_mem_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_fml_mem_responder.sv
// Directed and scoreboarded bench for fml_mem_responder.
// Table vectors plus hand sequences for stall, proto_err and reset.
module tb_fml_mem_responder;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall;
    logic        cop_mem_error;
    logic        cfg_stall_en;
    logic        cfg_err_en;
    logic [15:0] txn_count;
    logic        proto_err;

    fml_mem_responder #(
        .MEM_AW    (10),
        .STALL_MAX (3),
        .ERR_BASE  (32'hF000_0000),
        .ERR_LIMIT (32'hF000_1000),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .cop_mem_cen   (cop_mem_cen),
        .cop_mem_wen   (cop_mem_wen),
        .cop_mem_addr  (cop_mem_addr),
        .cop_mem_wdata (cop_mem_wdata),
        .cop_mem_ben   (cop_mem_ben),
        .cop_mem_rdata (cop_mem_rdata),
        .cop_mem_stall (cop_mem_stall),
        .cop_mem_error (cop_mem_error),
        .cfg_stall_en  (cfg_stall_en),
        .cfg_err_en    (cfg_err_en),
        .txn_count     (txn_count),
        .proto_err     (proto_err)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;
    logic [31:0] sb [64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [3:0] peek_k();
        if (!cfg_stall_en) return 4'd0;
        return (m_lfsr[3:0] > 4'd3) ? 4'd3 : m_lfsr[3:0];
    endfunction

    // Called just after a negedge; returns at the completion negedge.
    task automatic do_txn(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rd, output logic er,
                          output int ns);
        logic [3:0] ek;
        cop_mem_cen   = 1'b1;
        cop_mem_wen   = w;
        cop_mem_addr  = a;
        cop_mem_wdata = d;
        cop_mem_ben   = b;
        ek = peek_k();
        @(posedge g_clk);
        m_lfsr = lfsr_step(m_lfsr);
        m_cnt  = m_cnt + 16'd1;
        ns = 0;
        @(negedge g_clk);
        while (cop_mem_stall && ns < 20) begin
            chk("err_in_stall", {31'd0, cop_mem_error}, 32'd0);
            ns++;
            @(negedge g_clk);
        end
        if (ns >= 20) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got %0d cycles want <=3", ns);
        end
        chk("stall_len", ns, {28'd0, ek});
        rd = cop_mem_rdata;
        er = cop_mem_error;
    endtask

    task automatic go_idle();
        cop_mem_cen = 1'b0;
        @(negedge g_clk);
    endtask

    vec_t        vt [15];
    logic [31:0] rd;
    logic        er;
    int          ns;
    int          nz;
    int          guard;

    initial begin
        g_resetn      = 1'b0;
        cop_mem_cen   = 1'b0;
        cop_mem_wen   = 1'b0;
        cop_mem_addr  = 32'd0;
        cop_mem_wdata = 32'd0;
        cop_mem_ben   = 4'h0;
        cfg_stall_en  = 1'b0;
        cfg_err_en    = 1'b1;
        m_lfsr        = 16'hACE1;
        m_cnt         = 16'd0;

        vt[0]  = '{1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 0};
        vt[1]  = '{0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 0};
        vt[2]  = '{1, 32'h0000_0100, 32'h0000_AB00, 4'h2, 32'h0, 0};
        vt[3]  = '{0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_ABEF, 0};
        vt[4]  = '{1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0, 0};
        vt[5]  = '{0, 32'hF000_0004, 32'h0, 4'hF, 32'h0, 1};
        vt[6]  = '{1, 32'hF000_0004, 32'h1111_1111, 4'hF, 32'h0, 1};
        vt[7]  = '{0, 32'h0000_0004, 32'h0, 4'hF, 32'hCAFE_F00D, 0};
        vt[8]  = '{1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0, 0};
        vt[9]  = '{0, 32'hF000_1000, 32'h0, 4'hF, 32'h1234_5678, 0};
        vt[10] = '{1, 32'h0000_0FFC, 32'h0, 4'hF, 32'h0, 0};
        vt[11] = '{1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'h9, 32'h0, 0};
        vt[12] = '{0, 32'hEFFF_FFFC, 32'h0, 4'hF, 32'hA500_00A5, 0};
        vt[13] = '{0, 32'hF000_0FFC, 32'h0, 4'hF, 32'h0, 1};
        vt[14] = '{0, 32'hEFFF_FFF0, 32'h0, 4'hF, 32'h0, 0};
        vt[14].wen = 1'b1;

        repeat (3) @(negedge g_clk);
        g_resetn = 1'b1;

        // Idle after reset.
        chk("rst_rdata", cop_mem_rdata, 32'd0);
        chk("rst_proto", {31'd0, proto_err}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge g_clk);
            chk("idle_stall", {31'd0, cop_mem_stall}, 32'd0);
            chk("idle_error", {31'd0, cop_mem_error}, 32'd0);
            chk("idle_count", {16'd0, txn_count}, 32'd0);
        end

        // Back-to-back table, no stalls, error window on.
        for (int i = 0; i < 15; i++) begin
            do_txn(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].ben,
                   rd, er, ns);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_error", i), {31'd0, er},
                {31'd0, vt[i].err});
            if (i == 1) chk("count_after_2", {16'd0, txn_count}, 32'd2);
        end
        chk("count_table", {16'd0, txn_count}, {16'd0, m_cnt});
        go_idle();
        chk("idle_err_clr", {31'd0, cop_mem_error}, 32'd0);
        chk("idle_rd_hold", cop_mem_rdata, 32'd0);

        // Random traffic with stall injection against a scoreboard.
        cfg_stall_en = 1'b1;
        cfg_err_en   = 1'b0;
        nz = 0;
        for (int i = 0; i < 64; i++) begin
            sb[i] = $urandom;
            do_txn(1'b1, 32'h200 + 32'(i) * 4, sb[i], 4'hF, rd, er, ns);
            if (ns > 0) nz++;
        end
        for (int i = 0; i < 200; i++) begin
            logic        w;
            int          j;
            logic [31:0] d;
            logic [3:0]  b;
            w = 1'($urandom_range(0, 1));
            j = $urandom_range(0, 63);
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            do_txn(w, 32'h200 + 32'(j) * 4, d, b, rd, er, ns);
            if (ns > 0) nz++;
            if (w) begin
                for (int q = 0; q < 4; q++)
                    if (b[q]) sb[j][8*q +: 8] = d[8*q +: 8];
                chk("rnd_wr_rdata", rd, 32'd0);
            end else begin
                chk("rnd_rd_rdata", rd, sb[j]);
            end
            chk("rnd_error", {31'd0, er}, 32'd0);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        do_txn(1'b0, 32'h200 + 32'd17 * 4, 32'd0, 4'hF, rd, er, ns);
        chk("rnd_final_rd", rd, sb[17]);
        go_idle();
        total++;
        if (nz == 0) begin
            bad++;
            $display("FAIL stall_seen: got 0 stalled txns want >0");
        end
        chk("rnd_proto", {31'd0, proto_err}, 32'd0);
        chk("rnd_count", {16'd0, txn_count}, {16'd0, m_cnt});

        // Drop cen in the middle of a stall.
        guard = 0;
        while (peek_k() == 0 && guard < 50) begin
            do_txn(1'b0, 32'h200, 32'd0, 4'hF, rd, er, ns);
            guard++;
        end
        go_idle();
        cop_mem_cen  = 1'b1;
        cop_mem_wen  = 1'b0;
        cop_mem_addr = 32'h200;
        @(posedge g_clk);
        m_lfsr = lfsr_step(m_lfsr);
        m_cnt  = m_cnt + 16'd1;
        @(negedge g_clk);
        chk("pe_stall", {31'd0, cop_mem_stall}, 32'd1);
        cop_mem_cen = 1'b0;
        ns = 0;
        while (cop_mem_stall && ns < 20) begin
            @(negedge g_clk);
            ns++;
        end
        chk("pe_set", {31'd0, proto_err}, 32'd1);
        chk("pe_done_rd", cop_mem_rdata, sb[0]);
        repeat (3) @(negedge g_clk);
        chk("pe_sticky", {31'd0, proto_err}, 32'd1);
        chk("pe_idle_err", {31'd0, cop_mem_error}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        guard = 0;
        while (peek_k() == 0 && guard < 50) begin
            do_txn(1'b0, 32'h200, 32'd0, 4'hF, rd, er, ns);
            guard++;
        end
        go_idle();
        cop_mem_cen  = 1'b1;
        cop_mem_addr = 32'h204;
        @(posedge g_clk);
        @(negedge g_clk);
        chk("rs_pre_stall", {31'd0, cop_mem_stall}, 32'd1);
        #1 g_resetn = 1'b0;
        #1;
        chk("rs_stall", {31'd0, cop_mem_stall}, 32'd0);
        chk("rs_error", {31'd0, cop_mem_error}, 32'd0);
        chk("rs_count", {16'd0, txn_count}, 32'd0);
        chk("rs_proto", {31'd0, proto_err}, 32'd0);
        chk("rs_rdata", cop_mem_rdata, 32'd0);
        cop_mem_cen = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        m_lfsr = 16'hACE1;
        m_cnt  = 16'd0;
        @(negedge g_clk);

        // RAM survives reset; seed gives a one-cycle stall first.
        do_txn(1'b0, 32'h200 + 32'd5 * 4, 32'd0, 4'hF, rd, er, ns);
        chk("post_rst_rd", rd, sb[5]);
        chk("post_rst_ns", ns, 32'd1);
        go_idle();
        chk("post_rst_cnt", {16'd0, txn_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
